// File: rtl/rv_pkg.sv
// Shared core-wide constants: datapath width, return-stack depth and the
// link-register indices the control unit uses to derive RAS push/pop.
package rv_pkg;

    localparam int RV_XLEN   = 32;
    localparam int RAS_DEPTH = 8;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

endpackage : rv_pkg

// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of link addresses that gives the
// fetch stage a predicted return target ahead of JALR resolution.
module return_addr_stack
    import rv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int DEPTH = RAS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_addr,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     pred_valid,
    output logic [XLEN-1:0]          pred_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] entries_q [DEPTH];
    logic [PW-1:0]   tp_q, tp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic            wr_en_s;
    logic [PW-1:0]   wr_idx_s;
    logic [PW-1:0]   top_idx_s;

    assign top_idx_s = tp_q - PW'(1);

    // Per-edge action selection, highest priority first.
    always_comb begin
        tp_d        = tp_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = tp_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else if (push && pop) begin
            wr_en_s = 1'b1;
            if (count_q == {CW{1'b0}}) begin
                // Nothing to replace: behaves as a plain push, no underflow.
                tp_d    = tp_q + PW'(1);
                count_d = CW'(1);
            end else begin
                wr_idx_s = top_idx_s;
            end
        end else if (push) begin
            wr_en_s = 1'b1;
            tp_d    = tp_q + PW'(1);
            if (count_q == FULL_COUNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (count_q == {CW{1'b0}}) begin
                underflow_d = 1'b1;
            end else begin
                tp_d    = top_idx_s;
                count_d = count_q - CW'(1);
            end
        end else begin
            tp_d = tp_q;
        end
    end

    // Pointer, occupancy and event-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q        <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tp_q        <= tp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; kept as a flat array so reset can clear every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            entries_q[wr_idx_s] <= push_addr;
        end
    end

    assign pred_valid = (count_q != {CW{1'b0}});
    assign pred_addr  = entries_q[top_idx_s];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule : return_addr_stack

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_return_addr_stack;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              flush = 1'b0;
    logic [XLEN-1:0]   push_addr = '0;
    logic              pred_valid;
    logic [XLEN-1:0]   pred_addr;
    logic [$clog2(DEPTH):0] count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] model_q [$];
    bit              exp_ovf = 1'b0;
    bit              exp_unf = 1'b0;

    return_addr_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_addr  (push_addr),
        .pop        (pop),
        .flush      (flush),
        .pred_valid (pred_valid),
        .pred_addr  (pred_addr),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a LIFO of link addresses, oldest dropped beyond DEPTH.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
            if (flush) begin
                model_q.delete();
            end else if (push && pop) begin
                if (model_q.size() == 0) model_q.push_back(push_addr);
                else model_q[model_q.size()-1] = push_addr;
            end else if (push) begin
                model_q.push_back(push_addr);
                if (model_q.size() > DEPTH) begin
                    void'(model_q.pop_front());
                    exp_ovf = 1'b1;
                end
            end else if (pop) begin
                if (model_q.size() == 0) exp_unf = 1'b1;
                else void'(model_q.pop_back());
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count", XLEN'(count), XLEN'(model_q.size()));
            chk("m_valid", XLEN'(pred_valid), XLEN'(model_q.size() != 0));
            chk("m_ovf", XLEN'(overflow), XLEN'(exp_ovf));
            chk("m_unf", XLEN'(underflow), XLEN'(exp_unf));
            if (model_q.size() != 0) chk("m_addr", pred_addr, model_q[model_q.size()-1]);
        end
    end

    task automatic cyc(input bit p, input bit o, input bit f, input logic [XLEN-1:0] a);
        push = p; pop = o; flush = f; push_addr = a;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", XLEN'(pred_valid), 32'h0);
        chk("rst_addr", pred_addr, 32'h0);
        chk("rst_count", XLEN'(count), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ovf", XLEN'(overflow), 32'h0);
        chk("rst_unf", XLEN'(underflow), 32'h0);

        // Basic push x3 / pop x3
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0104);
        chk("t1_latency", pred_addr, 32'h0000_0104);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0208);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_030C);
        chk("t1_count3", XLEN'(count), 32'd3);
        chk("t1_pop0", pred_addr, 32'h0000_030C);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t1_pop1", pred_addr, 32'h0000_0208);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t1_pop2", pred_addr, 32'h0000_0104);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t1_empty_valid", XLEN'(pred_valid), 32'h0);
        chk("t1_empty_count", XLEN'(count), 32'h0);

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i));
            if (i < 8) chk("t2_no_ovf", XLEN'(overflow), 32'h0);
        end
        chk("t2_ovf", XLEN'(overflow), 32'h1);
        chk("t2_count", XLEN'(count), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_pop_addr", pred_addr, 32'h120 - 32'(4 * k));
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            if (k == 0) chk("t2_ovf_clear", XLEN'(overflow), 32'h0);
        end
        chk("t2_drained", XLEN'(count), 32'h0);

        // Underflow, then push+pop on empty
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t3_unf", XLEN'(underflow), 32'h1);
        chk("t3_count", XLEN'(count), 32'h0);
        chk("t3_valid", XLEN'(pred_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0400);
        chk("t3_pp_count", XLEN'(count), 32'd1);
        chk("t3_pp_addr", pred_addr, 32'h0000_0400);
        chk("t3_pp_unf", XLEN'(underflow), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Replace top
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0500);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0600);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0700);
        chk("t4_count", XLEN'(count), 32'd2);
        chk("t4_addr", pred_addr, 32'h0000_0700);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t4_older", pred_addr, 32'h0000_0500);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Flush beats push
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h800 + 32'(i));
        cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("t5_count", XLEN'(count), 32'h0);
        chk("t5_valid", XLEN'(pred_valid), 32'h0);
        idle();

        // Pseudo-random traffic against the model, covers pointer wrap both ways
        for (int n = 0; n < 300; n++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0), $urandom);
        end
        idle();

        // Asynchronous reset between clock edges
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'hA00 + 32'(4 * i));
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", XLEN'(count), 32'h0);
        chk("t6_valid", XLEN'(pred_valid), 32'h0);
        chk("t6_addr", pred_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_unf", XLEN'(underflow), 32'h1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_return_addr_stack
